onchip_mem_test_master: RTL and testbench

- Avalon-MM master that drives the s1 port of the 8192x32 single-port on-chip RAM slave (13-bit word address, byteenable, chipselect, write, clken; read latency 1, no waitrequest).
- Executes one command per start pulse: fill a word range with a deterministic pattern, verify a range against that pattern, or fill then verify.
- Reports mismatch count and the first failing address.
- Used for per-core scratchpad bring-up and self-test in the multi-core platform.

---
 rtl/onchip_mem_test_master.sv | 193 +++++++++++++++++++
 tb/tb_onchip_mem_test_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_test_master.sv
// Avalon-MM master for the on-chip RAM s1 port: fills a word range with seed+i,
// verifies it, or both, and reports the mismatch count and the first failing address.
module onchip_mem_test_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 14
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    length,
    input  logic [DATA_W-1:0]   seed,
    input  logic                hold,
    output logic                busy,
    output logic                done,
    output logic                cmd_err,
    output logic [LEN_W-1:0]    err_count,
    output logic                first_err_valid,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   av_address,
    output logic [DATA_W/8-1:0] av_byteenable,
    output logic                av_chipselect,
    output logic                av_write,
    output logic [DATA_W-1:0]   av_writedata,
    output logic                av_clken,
    input  logic [DATA_W-1:0]   av_readdata
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_VERIFY = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [LEN_W-1:0]  DEPTH    = LEN_W'(2**ADDR_W);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              cs_q, cs_d, wr_q, wr_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [LEN_W-1:0]  err_cnt_q, err_cnt_d;
    logic              ferr_vld_q, ferr_vld_d;
    logic [ADDR_W-1:0] ferr_addr_q, ferr_addr_d;
    logic              cmd_err_q, cmd_err_d;
    logic              last_idx, mismatch, illegal;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        base_d      = base_q;
        len_d       = len_q;
        seed_d      = seed_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cs_d        = cs_q;
        wr_d        = wr_q;
        cmp_vld_d   = cmp_vld_q;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        err_cnt_d   = err_cnt_q;
        ferr_vld_d  = ferr_vld_q;
        ferr_addr_d = ferr_addr_q;
        cmd_err_d   = cmd_err_q;
        last_idx    = (idx_q == len_q - LEN_ONE);
        mismatch    = cmp_vld_q && (av_readdata != cmp_exp_q);
        illegal     = (mode == 2'b11) || (length > DEPTH);

        // Acceptance ignores hold so a command can be queued while the memory is frozen.
        if (state_q == S_IDLE) begin
            if (start) begin
                mode_d      = mode;
                base_d      = base_addr;
                len_d       = length;
                seed_d      = seed;
                err_cnt_d   = '0;
                ferr_vld_d  = 1'b0;
                ferr_addr_d = '0;
                cmd_err_d   = illegal;
                idx_d       = '0;
                addr_d      = base_addr;
                data_d      = seed;
                if (illegal || length == '0) begin
                    state_d = S_FINISH;
                end else begin
                    cs_d    = 1'b1;
                    wr_d    = (mode != 2'b01);
                    state_d = (mode == 2'b01) ? S_VERIFY : S_FILL;
                end
            end
        end else if (!hold) begin
            // The pipe tags each read with its expected word for the compare one cycle later.
            cmp_vld_d  = (state_q == S_VERIFY);
            cmp_exp_d  = data_q;
            cmp_addr_d = addr_q;
            if (mismatch) begin
                err_cnt_d = err_cnt_q + LEN_ONE;
                if (!ferr_vld_q) begin
                    ferr_vld_d  = 1'b1;
                    ferr_addr_d = cmp_addr_q;
                end
            end
            case (state_q)
                S_FILL, S_VERIFY: begin
                    if (!last_idx) begin
                        idx_d  = idx_q + LEN_ONE;
                        addr_d = addr_q + ADDR_ONE;
                        data_d = data_q + DATA_ONE;
                    end else if (state_q == S_FILL && mode_q == 2'b10) begin
                        state_d = S_VERIFY;
                        idx_d   = '0;
                        addr_d  = base_q;
                        data_d  = seed_q;
                        wr_d    = 1'b0;
                    end else begin
                        cs_d    = 1'b0;
                        wr_d    = 1'b0;
                        state_d = (state_q == S_FILL) ? S_FINISH : S_DRAIN;
                    end
                end
                S_DRAIN: state_d = S_FINISH;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            seed_q      <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            err_cnt_q   <= '0;
            ferr_vld_q  <= 1'b0;
            ferr_addr_q <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            len_q       <= len_d;
            seed_q      <= seed_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            err_cnt_q   <= err_cnt_d;
            ferr_vld_q  <= ferr_vld_d;
            ferr_addr_q <= ferr_addr_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // done is gated by hold so a frozen FINISH postpones the pulse rather than stretching it.
    assign busy            = (state_q == S_FILL) || (state_q == S_VERIFY) || (state_q == S_DRAIN);
    assign done            = (state_q == S_FINISH) && !hold;
    assign cmd_err         = cmd_err_q;
    assign err_count       = err_cnt_q;
    assign first_err_valid = ferr_vld_q;
    assign first_err_addr  = ferr_addr_q;
    assign av_address      = addr_q;
    assign av_byteenable   = '1;
    assign av_chipselect   = cs_q;
    assign av_write        = wr_q;
    assign av_writedata    = data_q;
    assign av_clken        = ~hold;

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Bench for onchip_mem_test_master: RAM model on s1, bus logger, and a
// range-level reference model that predicts bus traffic, counts and done timing.
module tb_onchip_mem_test_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [12:0] base_addr = '0;
    logic [13:0] length = '0;
    logic [31:0] seed = '0;
    logic        hold = 1'b0;
    logic        busy, done, cmd_err, first_err_valid;
    logic [13:0] err_count;
    logic [12:0] first_err_addr, av_address;
    logic [3:0]  av_byteenable;
    logic        av_chipselect, av_write, av_clken;
    logic [31:0] av_writedata, av_readdata;

    onchip_mem_test_master dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .seed(seed), .hold(hold),
        .busy(busy), .done(done), .cmd_err(cmd_err), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
        .av_address(av_address), .av_byteenable(av_byteenable),
        .av_chipselect(av_chipselect), .av_write(av_write),
        .av_writedata(av_writedata), .av_clken(av_clken), .av_readdata(av_readdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] data;
        logic [31:0] e;
    } acc_t;

    logic [31:0] mem [0:8191];
    logic [31:0] ref_mem [0:8191];
    logic [31:0] rd_q = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] edge_n = '0;
    logic        inj_en = 1'b0;
    logic [12:0] inj_addr = '0;
    logic [31:0] inj_data = '0;
    acc_t        log_q[$];
    int          checks = 0;
    int          failures = 0;

    assign av_readdata = rd_q;

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A5A_0F0F ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    // Single-port RAM, read latency 1, frozen when clken is low; also logs every access.
    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (inj_en) begin
            mem[inj_addr] <= inj_data;
        end else if (av_clken && av_chipselect) begin
            if (av_write) mem[av_address] <= av_writedata;
            else          rd_q <= mem[av_address];
            log_q.push_back('{wr: av_write, addr: av_address, data: av_writedata, e: edge_n + 1});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic inject(input logic [12:0] a, input logic [31:0] d);
        @(negedge clk);
        inj_en = 1'b1; inj_addr = a; inj_data = d;
        @(negedge clk);
        inj_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic run_cmd(input logic [1:0] m, input logic [12:0] b, input logic [13:0] n,
                           input logic [31:0] s, input int hold_at, input int hold_len,
                           input int bstart_at, input string tag);
        acc_t        exp_q[$];
        acc_t        g, x;
        int          exp_done, exp_err, off, cyc, clk_low, clk_bad, nlog, bad, lb;
        bit          exp_ce, got;
        logic [12:0] a, exp_fa;
        logic [31:0] e0;
        exp_ce = (m == 2'b11) || (n > 14'd8192);
        exp_err = 0; exp_fa = '0;
        if (exp_ce || n == 0) exp_done = 1;
        else if (m == 2'b00)  exp_done = n + 1;
        else if (m == 2'b01)  exp_done = n + 2;
        else                  exp_done = 2 * n + 2;
        exp_done += hold_len;
        if (!exp_ce && n != 0) begin
            if (m != 2'b01) begin
                for (int i = 0; i < n; i++) begin
                    a = b + 13'(i);
                    ref_mem[a] = s + 32'(i);
                    exp_q.push_back('{wr: 1'b1, addr: a, data: s + 32'(i), e: 32'(i + 1)});
                end
            end
            if (m != 2'b00) begin
                off = (m == 2'b10) ? int'(n) : 0;
                for (int i = 0; i < n; i++) begin
                    a = b + 13'(i);
                    exp_q.push_back('{wr: 1'b0, addr: a, data: '0, e: 32'(off + i + 1)});
                    if (ref_mem[a] != s + 32'(i)) begin
                        if (exp_err == 0) exp_fa = a;
                        exp_err++;
                    end
                end
            end
        end

        @(negedge clk);
        lb = log_q.size();
        e0 = edge_n + 1;
        start = 1'b1; mode = m; base_addr = b; length = n; seed = s;
        cyc = 0; got = 0; clk_low = 0; clk_bad = 0;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (av_clken !== ~hold) clk_bad++;
            if (av_clken === 1'b0) clk_low++;
            if (done === 1'b1) begin got = 1; break; end
            hold = (hold_len > 0) && (cyc >= hold_at) && (cyc < hold_at + hold_len);
            start = (bstart_at != 0) && (cyc == bstart_at);
            if (start) begin mode = 2'b01; base_addr = b + 13'd5; length = 14'd2; end
        end
        hold = 1'b0; start = 1'b0;
        check({tag, ".done_seen"}, got, 1'b1);
        check({tag, ".done_cycle"}, cyc, exp_done);
        check({tag, ".busy_at_done"}, busy, 1'b0);
        check({tag, ".cmd_err"}, cmd_err, exp_ce);
        check({tag, ".err_count"}, err_count, exp_err);
        check({tag, ".first_err_valid"}, first_err_valid, exp_err != 0);
        check({tag, ".first_err_addr"}, first_err_addr, exp_fa);
        check({tag, ".clken_low_cycles"}, clk_low, hold_len);
        check({tag, ".clken_tracks_hold"}, clk_bad, 0);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, done, 1'b0);
        nlog = log_q.size() - lb;
        check({tag, ".access_count"}, nlog, exp_q.size());
        bad = 0;
        for (int k = 0; k < nlog && k < exp_q.size(); k++) begin
            g = log_q[lb + k];
            x = exp_q[k];
            if (g.wr !== x.wr || g.addr !== x.addr || (x.wr && g.data !== x.data) ||
                (hold_len == 0 && (g.e - e0) !== x.e)) bad++;
        end
        check({tag, ".access_content"}, bad, 0);
    endtask

    initial begin
        int          v, nerr, d0, ha, hl;
        logic [1:0]  m;
        logic [12:0] b;
        logic [13:0] n;
        logic [31:0] s;
        int          spur;
        for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);

        #2 reset_n = 1'b0;
        #1;
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.cmd_err", cmd_err, 1'b0);
        check("rst.first_err_valid", first_err_valid, 1'b0);
        check("rst.err_count", err_count, 14'd0);
        check("rst.first_err_addr", first_err_addr, 13'd0);
        check("rst.cs_wr", {av_chipselect, av_write}, 2'b00);
        check("rst.addr_data", {av_address, av_writedata}, 45'd0);
        check("rst.byteenable", av_byteenable, 4'hF);
        check("rst.clken", av_clken, 1'b1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        run_cmd(2'b10, 13'h0100, 14'd16, 32'hA5A5_0000, 0, 0, 0, "fill_verify");
        run_cmd(2'b00, 13'h1FFE, 14'd4, 32'd5, 0, 0, 0, "wrap");
        run_cmd(2'b00, 13'h0000, 14'd8, 32'd0, 0, 0, 0, "inj_fill");
        inject(13'd3, 32'h0000_DEAD);
        inject(13'd6, 32'h0000_BEEF);
        run_cmd(2'b01, 13'h0000, 14'd8, 32'd0, 0, 0, 0, "inj_verify");
        run_cmd(2'b01, 13'h0000, 14'd8, 32'd0, 4, 3, 0, "hold_verify");
        run_cmd(2'b00, 13'h0500, 14'd0, 32'd9, 0, 0, 0, "len_zero");
        run_cmd(2'b11, 13'h0500, 14'd4, 32'd9, 0, 0, 0, "mode_illegal");
        run_cmd(2'b00, 13'h0500, 14'd8193, 32'd9, 0, 0, 0, "len_illegal");
        run_cmd(2'b00, 13'h0200, 14'd10, 32'h1111_0000, 0, 0, 3, "busy_start");

        @(negedge clk);
        start = 1'b1; mode = 2'b00; base_addr = 13'h0040; length = 14'd16; seed = 32'h77;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid.busy_before", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst_mid.cs_wr", {av_chipselect, av_write}, 2'b00);
        check("rst_mid.busy_done", {busy, done}, 2'b00);
        spur = 0;
        repeat (2) @(negedge clk) if (done !== 1'b0 || av_chipselect !== 1'b0) spur++;
        reset_n = 1'b1;
        repeat (8) @(negedge clk) if (done !== 1'b0 || av_chipselect !== 1'b0 || busy !== 1'b0) spur++;
        check("rst_mid.quiet_after", spur, 0);
        run_cmd(2'b00, 13'h0040, 14'd16, 32'h77, 0, 0, 0, "after_reset");

        for (int r = 0; r < 14; r++) begin
            v = int'($urandom_range(0, 9));
            m = (v < 3) ? 2'b00 : (v < 6) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
            b = 13'($urandom);
            n = 14'($urandom_range(0, 40));
            s = $urandom;
            if (m == 2'b01 && $urandom_range(0, 1) == 1) begin
                run_cmd(2'b00, b, n, s, 0, 0, 0, "rnd_prefill");
                nerr = int'($urandom_range(1, 3));
                for (int k = 0; k < nerr && n > 0; k++)
                    inject(b + 13'($urandom_range(0, int'(n) - 1)), $urandom);
            end
            ha = 0; hl = 0;
            if (m != 2'b11 && n >= 6 && $urandom_range(0, 1) == 1) begin
                d0 = (m == 2'b00) ? int'(n) + 1 : (m == 2'b01) ? int'(n) + 2 : 2 * int'(n) + 2;
                hl = int'($urandom_range(1, 4));
                ha = int'($urandom_range(2, d0 - 1 - hl));
            end
            run_cmd(m, b, n, s, ha, hl, 0, "rnd");
        end

        run_cmd(2'b10, 13'h1234, 14'd8192, $urandom, 0, 0, 0, "full_depth");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
